// File: rtl/gate_test_pkg.sv
// Purpose: shared types and constants for the 2-input gate test sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, vector count, vector-to-input mapping, common truth tables.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 4;

  typedef logic [1:0] vec_idx_t;

  // Drive pair for gate inputs; packed as {B,A} so it lines up with table indexing.
  typedef struct packed {
    logic b;
    logic a;
  } ab_t;

  // Entry i (2 bits) is the {B,A} drive for vector index i: 00, 10, 01, 11 in A/B order.
  localparam logic [2*NUM_VECTORS-1:0] VECTOR_MAP = {2'b11, 2'b10, 2'b01, 2'b00};

  // Expected-output tables, bit i = output for vector index i ({B,A} = i).
  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;

  function automatic ab_t vector_ab(input vec_idx_t idx);
    ab_t v;
    v = VECTOR_MAP[{idx, 1'b0} +: 2];
    return v;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Purpose: control/result bundle between a test controller, the gate under test and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; Start is a single-cycle request, ignored while a run is in flight.
// Ports: master drives Start/Abort/Expected_Table/Gate_Output and observes the rest; slave is the sequencer.
interface gate_test_sequencer_if;
  import gate_test_pkg::*;

  logic                   Start;
  logic                   Abort;
  logic [NUM_VECTORS-1:0] Expected_Table;
  logic                   Gate_Output;
  logic                   Input_A;
  logic                   Input_B;
  logic                   Busy;
  logic                   Done;
  logic                   Pass;
  logic [2:0]             Error_Count;
  logic [NUM_VECTORS-1:0] Result;

  modport master (
    output Start, Abort, Expected_Table, Gate_Output,
    input  Input_A, Input_B, Busy, Done, Pass, Error_Count, Result
  );

  modport slave (
    input  Start, Abort, Expected_Table, Gate_Output,
    output Input_A, Input_B, Busy, Done, Pass, Error_Count, Result
  );

endinterface

// File: rtl/gate_test_sequencer_settle_timer.sv
// Purpose: settle-time counter; pulses done_o on the last settle cycle of a vector.
// Latency: done_o is combinational from the count, high when cnt == SETTLE_CYCLES-1 and enabled.
// Backpressure: none; clear_i has priority over enable_i.
// Ports: clk_i, rst_i (async high), clear_i, enable_i -> done_o.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign done_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/gate_test_sequencer.sv
// Purpose: walks a 2-input gate through vectors 00,10,01,11, samples its output after a settle time and scores it.
// Latency: Done/Pass valid 4*(SETTLE_CYCLES+1) cycles after the Start edge; each vector held SETTLE_CYCLES+1 cycles.
// Backpressure: Start ignored while Busy; Abort wins over Start and returns to IDLE from any state.
// Ports: Clock, Reset (async high), bus (slave modport: Start/Abort/Expected_Table/Gate_Output in;
//        Input_A/Input_B/Busy/Done/Pass/Error_Count/Result out, all registered).
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  gate_test_sequencer_if.slave  bus
);

  state_e                 state_q;
  vec_idx_t               idx_q;
  logic [NUM_VECTORS-1:0] table_q;
  logic [NUM_VECTORS-1:0] result_q;
  logic [NUM_VECTORS-1:0] result_d;
  logic [2:0]             err_q;
  logic [2:0]             err_d;
  ab_t                    ab_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;

  logic start_ok;
  logic last_vec;
  logic mismatch;
  logic timer_clr;
  logic timer_en;
  logic timer_done;

  // Start only counts from a resting state and only if Abort is not also present.
  assign start_ok = bus.Start && !bus.Abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_vec = (idx_q == vec_idx_t'(NUM_VECTORS - 1));
  assign mismatch = (bus.Gate_Output != table_q[idx_q]);
  assign err_d    = err_q + {2'b00, mismatch};

  always_comb begin
    result_d        = result_q;
    result_d[idx_q] = bus.Gate_Output;
  end

  // Counter restarts whenever a new vector is driven: on run start and on each non-final sample.
  assign timer_clr = start_ok || ((state_q == ST_SAMPLE) && !last_vec && !bus.Abort);
  assign timer_en  = (state_q == ST_SETTLE);

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle_timer (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .clear_i  (timer_clr),
    .enable_i (timer_en),
    .done_o   (timer_done)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      table_q  <= '0;
      result_q <= '0;
      err_q    <= '0;
      ab_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else if (bus.Abort) begin
      // Result and Error_Count are deliberately kept so a partial run can be inspected.
      state_q <= ST_IDLE;
      ab_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            table_q  <= bus.Expected_Table;
            result_q <= '0;
            err_q    <= '0;
            idx_q    <= '0;
            ab_q     <= vector_ab(vec_idx_t'(0));
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer_done) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          result_q <= result_d;
          err_q    <= err_d;
          if (last_vec) begin
            // Inputs stay on the last vector while results are held in DONE.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 3'd0);
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + vec_idx_t'(1);
            ab_q    <= vector_ab(idx_q + vec_idx_t'(1));
            state_q <= ST_SETTLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Input_A     = ab_q.a;
  assign bus.Input_B     = ab_q.b;
  assign bus.Busy        = busy_q;
  assign bus.Done        = done_q;
  assign bus.Pass        = pass_q;
  assign bus.Error_Count = err_q;
  assign bus.Result      = result_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Purpose: self-checking bench for gate_test_sequencer with a truth-table gate model.
// Latency: expects Done 4*(S+1) cycles after Start, each vector held S+1 cycles.
// Backpressure: exercises ignored mid-run Start, Abort, Abort+Start and async reset.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  localparam int S     = 4;
  localparam int RUN_CYC = 4 * (S + 1);

  logic clk;
  logic rst;
  logic [3:0] gate_tt;   // behaviour of the gate under test, bit {B,A}

  int checks = 0;
  int errors = 0;

  gate_test_sequencer_if bus();

  gate_test_sequencer #(
    .SETTLE_CYCLES (S),
    .CNT_W         (8)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  assign bus.Gate_Output = gate_tt[{bus.Input_B, bus.Input_A}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] gate_tt;
    logic [3:0] exp_tt;
    logic       disturb;
    logic [3:0] res;
    logic [2:0] err;
    logic       pass;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk($sformatf("%s_ab", name), 32'({bus.Input_B, bus.Input_A}), 32'd0);
    chk($sformatf("%s_busy_done_pass", name), 32'({bus.Busy, bus.Done, bus.Pass}), 32'd0);
    chk($sformatf("%s_err", name), 32'(bus.Error_Count), 32'd0);
    chk($sformatf("%s_result", name), 32'(bus.Result), 32'd0);
  endtask

  // One complete run: checks the drive sequence every cycle, then the final scoreboard.
  task automatic run_check(input string name, input logic [3:0] g, input logic [3:0] e,
                           input logic dis, input logic [3:0] res, input logic [2:0] err,
                           input logic pas);
    int bad;
    int first_bad;
    gate_tt            = g;
    bus.Expected_Table = e;
    bus.Start          = 1'b1;
    tick();
    bus.Start = 1'b0;
    bad       = 0;
    first_bad = -1;
    for (int c = 0; c < RUN_CYC; c++) begin
      if (({bus.Input_B, bus.Input_A} !== 2'(c / (S + 1))) || (bus.Busy !== 1'b1) ||
          (bus.Done !== 1'b0)) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
      if (dis && c == 3) begin
        bus.Start          = 1'b1;
        bus.Expected_Table = ~e;
      end
      if (dis && c == 4) bus.Start = 1'b0;
      tick();
    end
    if (bad != 0) $display("  %s: first sequence deviation at cycle %0d", name, first_bad);
    chk($sformatf("%s_seq", name), 32'(bad), 32'd0);
    chk($sformatf("%s_done_busy", name), 32'({bus.Done, bus.Busy}), 32'b10);
    chk($sformatf("%s_hold_ab", name), 32'({bus.Input_B, bus.Input_A}), 32'b11);
    chk($sformatf("%s_result", name), 32'(bus.Result), 32'(res));
    chk($sformatf("%s_err", name), 32'(bus.Error_Count), 32'(err));
    chk($sformatf("%s_pass", name), 32'(bus.Pass), 32'(pas));
  endtask

  initial begin
    logic [3:0] rg;
    logic [3:0] re;
    logic       rd;

    tbl[0] = '{TT_AND,  TT_AND, 1'b0, 4'b1000, 3'd0, 1'b1};
    tbl[1] = '{4'b0000, TT_AND, 1'b0, 4'b0000, 3'd1, 1'b0};
    tbl[2] = '{4'b1111, TT_AND, 1'b0, 4'b1111, 3'd3, 1'b0};
    tbl[3] = '{TT_AND,  TT_AND, 1'b1, 4'b1000, 3'd0, 1'b1};
    tbl[4] = '{TT_OR,   TT_OR,  1'b0, 4'b1110, 3'd0, 1'b1};
    tbl[5] = '{TT_XOR,  TT_XOR, 1'b1, 4'b0110, 3'd0, 1'b1};
    tbl[6] = '{TT_NAND, TT_AND, 1'b0, 4'b0111, 3'd4, 1'b0};
    tbl[7] = '{TT_XOR,  TT_OR,  1'b0, 4'b0110, 3'd1, 1'b0};

    rst                = 1'b1;
    bus.Start          = 1'b0;
    bus.Abort          = 1'b0;
    bus.Expected_Table = 4'b0000;
    gate_tt            = TT_AND;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst = 1'b0;
    tick();
    chk_outputs_zero("post_reset");

    // Start and Abort together from IDLE: nothing happens.
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    tick();
    chk("start_abort_idle", 32'({bus.Busy, bus.Done, bus.Input_B, bus.Input_A}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("tbl%0d", i), tbl[i].gate_tt, tbl[i].exp_tt, tbl[i].disturb,
                tbl[i].res, tbl[i].err, tbl[i].pass);
    end

    // Abort 7 cycles into a run with a mismatch already scored on vector 0.
    gate_tt            = TT_NAND;
    bus.Expected_Table = TT_AND;
    bus.Start          = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (6) tick();
    chk("pre_abort_ab", 32'({bus.Input_B, bus.Input_A}), 32'b01);
    bus.Abort = 1'b1;
    tick();
    bus.Abort = 1'b0;
    chk("abort_ab", 32'({bus.Input_B, bus.Input_A}), 32'b00);
    chk("abort_busy_done", 32'({bus.Busy, bus.Done}), 32'b00);
    chk("abort_result", 32'(bus.Result), 32'b0001);
    chk("abort_err", 32'(bus.Error_Count), 32'd1);
    repeat (3) tick();
    chk("abort_stays_idle", 32'({bus.Busy, bus.Done, bus.Input_B, bus.Input_A}), 32'd0);
    run_check("after_abort", TT_AND, TT_AND, 1'b0, 4'b1000, 3'd0, 1'b1);

    // Asynchronous reset between edges mid-SETTLE.
    gate_tt            = TT_OR;
    bus.Expected_Table = TT_AND;
    bus.Start          = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    chk_outputs_zero("async_reset");
    #3;
    rst = 1'b0;
    tick();
    chk("after_reset_idle", 32'({bus.Busy, bus.Done}), 32'd0);
    run_check("after_reset", TT_AND, TT_AND, 1'b0, 4'b1000, 3'd0, 1'b1);

    // Random gates/tables against a table-level model: Result is the gate's own truth
    // table, Error_Count is the number of differing table entries.
    for (int i = 0; i < 16; i++) begin
      int n;
      rg = 4'($urandom_range(0, 15));
      re = 4'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      n  = $countones(rg ^ re);
      run_check($sformatf("rnd%0d", i), rg, re, rd, rg, 3'(n), (n == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
